snl_turn_controller: RTL and testbench
======================================

SNL_TURN_CONTROLLER -- requirements
Module: snl_turn_controller

Interface
REQ-001 Parameter FIRST_PLAYER, default 1, player who moves first after reset (1=P1, 0=P2).
REQ-002 Parameter LAST_SQ, default 49, winning square index.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start_game  input  1  level enable; game advances only while high.
REQ-006 dice_valid  input  1  dice value offered this cycle.
REQ-007 dice_val  input  3  dice value; legal range 1..6.
REQ-008 dice_ready  output  1  controller accepts a dice value this cycle.
REQ-009 player_turn  output  1  player owning the next roll (1=P1, 0=P2).
REQ-010 p1_position  output  6  P1 square, binary 0..LAST_SQ.
REQ-011 p2_position  output  6  P2 square, binary 0..LAST_SQ.
REQ-012 move_valid  output  1  one-cycle pulse: a move completed and positions are updated.
REQ-013 move_event  output  2  event of the last move: 0 plain, 1 ladder, 2 snake, 3 bounce (overshoot).
REQ-014 game_over  output  1  a player reached LAST_SQ.
REQ-015 winner  output  2  0 none, 1 P1, 2 P2.

Function
REQ-016 FSM states IDLE, WAIT_DICE, MOVE, APPLY, DONE.
REQ-017 IDLE -> WAIT_DICE when start_game=1; otherwise remain.
REQ-018 WAIT_DICE: dice_ready=1; handshake = dice_valid & dice_ready; dice_ready=0 in every other state.
REQ-019 WAIT_DICE with start_game=0 -> IDLE (pause); positions and player_turn retained; start_game=1 resumes.
REQ-020 Handshake with dice_val 0 or 7 is consumed and discarded: no move, no pulse, turn unchanged, stay in WAIT_DICE.
REQ-021 Legal handshake at edge E latches dice_val -> MOVE; start_game is ignored in MOVE and APPLY.
REQ-022 MOVE (edge E+1): sum = current player position + dice, computed 7 bits wide; sum > LAST_SQ -> landing = current position, event bounce; else landing = sum -> APPLY.
REQ-023 APPLY (edge E+2): landing passed through board map; mover position written; move_valid=1 for exactly that one cycle; move_event registered; player_turn toggles.
REQ-024 Board map: ladders 5->35, 20->30; snakes 36->17, 38->9, 48->38; all other squares map to themselves; map applied once (no chaining).
REQ-025 Event priority: bounce > snake > ladder > plain.
REQ-026 Mapped position = LAST_SQ in APPLY -> DONE; game_over=1, winner = mover; turn does not toggle.
REQ-027 DONE: absorbing; dice_ready=0, no further moves; exit only via reset.
REQ-028 Positions never exceed LAST_SQ; the non-moving player's position never changes during a move.
REQ-029 Both players may occupy the same square; no interaction.

Reset
REQ-030 reset=1 asynchronously forces IDLE, p1_position=0, p2_position=0, player_turn=FIRST_PLAYER, move_valid=0, move_event=0, game_over=0, winner=0.
REQ-031 Reset asserted during MOVE or APPLY aborts the move; no move_valid pulse is produced.

Structure
REQ-032 Package snl_pkg holds the FSM state enum, move_event encoding, LAST_SQ default and the snake/ladder table constants.
REQ-033 Board lookup is the combinational sub-module snl_board_map (in: square, out: mapped square, snake flag, ladder flag).

Verification
REQ-034 Reset, start_game=1, dice 3 -> move_valid at E+2, p1_position=3, move_event=0, player_turn=0 (FIRST_PLAYER=1).
REQ-035 P1 at 0 rolls 5 -> p1_position=35, move_event=1; P2 at 0 rolls 6 then P1 rolls 1 (P1 35->36) -> p1_position=17, move_event=2.
REQ-036 P1 at 45 rolls 6 -> p1_position=45, move_event=3, turn toggles; P1 at 43 rolls 6 -> p1_position=49, game_over=1, winner=1, dice_ready=0 thereafter.
REQ-037 Handshake with dice_val=0 then 7 -> no move_valid, positions and turn unchanged; following dice 2 accepted normally.
REQ-038 start_game dropped in WAIT_DICE -> IDLE, dice_ready=0, positions held; re-raise -> resumes with same player_turn.
REQ-039 reset pulsed one cycle after a handshake -> no move_valid, all outputs at REQ-030 values.

Source files
------------

// File: rtl/snl_pkg.sv
// Shared types and board constants for the snakes-and-ladders turn controller.
package snl_pkg;

    localparam int unsigned POS_W           = 6;
    localparam int unsigned SUM_W           = 7;
    localparam int unsigned DICE_W          = 3;
    localparam int unsigned WIN_W           = 2;
    localparam int unsigned DEFAULT_LAST_SQ = 49;

    localparam logic [POS_W-1:0] LADDER_A_FROM = 6'd5;
    localparam logic [POS_W-1:0] LADDER_A_TO   = 6'd35;
    localparam logic [POS_W-1:0] LADDER_B_FROM = 6'd20;
    localparam logic [POS_W-1:0] LADDER_B_TO   = 6'd30;
    localparam logic [POS_W-1:0] SNAKE_A_FROM  = 6'd36;
    localparam logic [POS_W-1:0] SNAKE_A_TO    = 6'd17;
    localparam logic [POS_W-1:0] SNAKE_B_FROM  = 6'd38;
    localparam logic [POS_W-1:0] SNAKE_B_TO    = 6'd9;
    localparam logic [POS_W-1:0] SNAKE_C_FROM  = 6'd48;
    localparam logic [POS_W-1:0] SNAKE_C_TO    = 6'd38;

    localparam logic [WIN_W-1:0] WIN_NONE = 2'd0;
    localparam logic [WIN_W-1:0] WIN_P1   = 2'd1;
    localparam logic [WIN_W-1:0] WIN_P2   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DICE = 3'd1,
        ST_MOVE      = 3'd2,
        ST_APPLY     = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        EV_PLAIN  = 2'd0,
        EV_LADDER = 2'd1,
        EV_SNAKE  = 2'd2,
        EV_BOUNCE = 2'd3
    } move_event_t;

    // Only faces 1..6 are playable; 0 and 7 are consumed and dropped.
    function automatic logic dice_legal(input logic [DICE_W-1:0] d);
        return (d != DICE_W'(0)) && (d != DICE_W'(7));
    endfunction

endpackage

// File: rtl/snl_board_map.sv
// Combinational board lookup: maps a landing square through at most one snake or ladder.
module snl_board_map
    import snl_pkg::*;
(
    input  logic [POS_W-1:0] square,
    output logic [POS_W-1:0] mapped,
    output logic             snake,
    output logic             ladder
);

    always_comb begin
        mapped = square;
        snake  = 1'b0;
        ladder = 1'b0;
        case (square)
            LADDER_A_FROM: begin mapped = LADDER_A_TO; ladder = 1'b1; end
            LADDER_B_FROM: begin mapped = LADDER_B_TO; ladder = 1'b1; end
            SNAKE_A_FROM:  begin mapped = SNAKE_A_TO;  snake  = 1'b1; end
            SNAKE_B_FROM:  begin mapped = SNAKE_B_TO;  snake  = 1'b1; end
            SNAKE_C_FROM:  begin mapped = SNAKE_C_TO;  snake  = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/snl_turn_controller.sv
// Two-player snakes-and-ladders turn sequencer: dice handshake, move, board map, win detect.
module snl_turn_controller
    import snl_pkg::*;
#(
    parameter logic        FIRST_PLAYER = 1'b1,
    parameter int unsigned LAST_SQ      = DEFAULT_LAST_SQ
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_game,
    input  logic              dice_valid,
    input  logic [DICE_W-1:0] dice_val,
    output logic              dice_ready,
    output logic              player_turn,
    output logic [POS_W-1:0]  p1_position,
    output logic [POS_W-1:0]  p2_position,
    output logic              move_valid,
    output logic [1:0]        move_event,
    output logic              game_over,
    output logic [WIN_W-1:0]  winner
);

    state_t              state, state_nxt;
    logic [DICE_W-1:0]   dice_q, dice_nxt;
    logic [POS_W-1:0]    landing_q, landing_nxt;
    logic                bounce_q, bounce_nxt;
    logic [POS_W-1:0]    p1_nxt, p2_nxt;
    logic                turn_nxt, ready_nxt, mv_nxt, over_nxt;
    logic [1:0]          event_nxt;
    logic [WIN_W-1:0]    winner_nxt;
    logic [POS_W-1:0]    cur_pos;
    logic [SUM_W-1:0]    sum;
    logic [POS_W-1:0]    map_sq;
    logic                map_snake, map_ladder;

    snl_board_map u_board_map (
        .square (landing_q),
        .mapped (map_sq),
        .snake  (map_snake),
        .ladder (map_ladder)
    );

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            dice_q      <= '0;
            landing_q   <= '0;
            bounce_q    <= 1'b0;
            p1_position <= '0;
            p2_position <= '0;
            player_turn <= FIRST_PLAYER;
            dice_ready  <= 1'b0;
            move_valid  <= 1'b0;
            move_event  <= 2'(EV_PLAIN);
            game_over   <= 1'b0;
            winner      <= WIN_NONE;
        end else begin
            state       <= state_nxt;
            dice_q      <= dice_nxt;
            landing_q   <= landing_nxt;
            bounce_q    <= bounce_nxt;
            p1_position <= p1_nxt;
            p2_position <= p2_nxt;
            player_turn <= turn_nxt;
            dice_ready  <= ready_nxt;
            move_valid  <= mv_nxt;
            move_event  <= event_nxt;
            game_over   <= over_nxt;
            winner      <= winner_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt   = state;
        dice_nxt    = dice_q;
        landing_nxt = landing_q;
        bounce_nxt  = bounce_q;
        p1_nxt      = p1_position;
        p2_nxt      = p2_position;
        turn_nxt    = player_turn;
        mv_nxt      = 1'b0;
        event_nxt   = move_event;
        over_nxt    = game_over;
        winner_nxt  = winner;
        cur_pos     = player_turn ? p1_position : p2_position;
        sum         = SUM_W'(cur_pos) + SUM_W'(dice_q);

        case (state)
            ST_IDLE: begin
                if (start_game) state_nxt = ST_WAIT_DICE;
            end
            ST_WAIT_DICE: begin
                // Pause takes priority over a dice offer in the same cycle.
                if (!start_game) begin
                    state_nxt = ST_IDLE;
                end else if (dice_valid && dice_legal(dice_val)) begin
                    dice_nxt  = dice_val;
                    state_nxt = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (sum > SUM_W'(LAST_SQ)) begin
                    landing_nxt = cur_pos;
                    bounce_nxt  = 1'b1;
                end else begin
                    landing_nxt = POS_W'(sum);
                    bounce_nxt  = 1'b0;
                end
                state_nxt = ST_APPLY;
            end
            ST_APPLY: begin
                if (player_turn) p1_nxt = map_sq;
                else             p2_nxt = map_sq;
                mv_nxt = 1'b1;
                if (bounce_q)        event_nxt = 2'(EV_BOUNCE);
                else if (map_snake)  event_nxt = 2'(EV_SNAKE);
                else if (map_ladder) event_nxt = 2'(EV_LADDER);
                else                 event_nxt = 2'(EV_PLAIN);
                if (map_sq == POS_W'(LAST_SQ)) begin
                    over_nxt   = 1'b1;
                    winner_nxt = player_turn ? WIN_P1 : WIN_P2;
                    state_nxt  = ST_DONE;
                end else begin
                    turn_nxt  = ~player_turn;
                    state_nxt = ST_WAIT_DICE;
                end
            end
            ST_DONE: state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase

        ready_nxt = (state_nxt == ST_WAIT_DICE);
    end

endmodule

// File: tb/tb_snl_turn_controller.sv
// Scoreboard bench for snl_turn_controller: reference model predicts each move's outcome.
module tb_snl_turn_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_game;
    logic       dice_valid;
    logic [2:0] dice_val;
    logic       dice_ready;
    logic       player_turn;
    logic [5:0] p1_position;
    logic [5:0] p2_position;
    logic       move_valid;
    logic [1:0] move_event;
    logic       game_over;
    logic [1:0] winner;

    always #5 clk = ~clk;

    snl_turn_controller #(.FIRST_PLAYER(1'b1), .LAST_SQ(49)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_game  (start_game),
        .dice_valid  (dice_valid),
        .dice_val    (dice_val),
        .dice_ready  (dice_ready),
        .player_turn (player_turn),
        .p1_position (p1_position),
        .p2_position (p2_position),
        .move_valid  (move_valid),
        .move_event  (move_event),
        .game_over   (game_over),
        .winner      (winner)
    );

    typedef struct {
        int p1;
        int p2;
        int ev;
        int turn;
        int over;
        int win;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   m_p1, m_p2, m_turn, m_over, m_win;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int bmap(input int s);
        case (s)
            5:       return 35;
            20:      return 30;
            36:      return 17;
            38:      return 9;
            48:      return 38;
            default: return s;
        endcase
    endfunction

    // Scoreboard consumer: every move_valid pulse must match the oldest prediction
    always @(negedge clk) begin
        exp_t e;
        if (move_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_move_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("latency",     cyc,         e.cyc);
                chk("p1_position", p1_position, e.p1);
                chk("p2_position", p2_position, e.p2);
                chk("move_event",  move_event,  e.ev);
                chk("player_turn", player_turn, e.turn);
                chk("game_over",   game_over,   e.over);
                chk("winner",      winner,      e.win);
            end
        end
    end

    task automatic check_model(input string tag);
        chk({tag, "_p1"},   p1_position, m_p1);
        chk({tag, "_p2"},   p2_position, m_p2);
        chk({tag, "_turn"}, player_turn, m_turn);
        chk({tag, "_over"}, game_over,   m_over);
        chk({tag, "_win"},  winner,      m_win);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, dice_ready,  0);
        chk({tag, "_p1"},    p1_position, 0);
        chk({tag, "_p2"},    p2_position, 0);
        chk({tag, "_turn"},  player_turn, 1);
        chk({tag, "_mv"},    move_valid,  0);
        chk({tag, "_ev"},    move_event,  0);
        chk({tag, "_over"},  game_over,   0);
        chk({tag, "_win"},   winner,      0);
    endtask

    task automatic model_reset();
        m_p1 = 0; m_p2 = 0; m_turn = 1; m_over = 0; m_win = 0;
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        reset = 1'b1; start_game = 1'b0; dice_valid = 1'b0;
        #2;
        check_reset_vals(tag);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dice_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("dice_ready_timeout", 0, 1);
    endtask

    // Offer one dice value; legal values are predicted and pushed to the scoreboard
    task automatic roll(input int d);
        bit ok;
        int pos, s, np, ev, ce;
        wait_ready(ok);
        if (!ok) return;
        dice_valid = 1'b1;
        dice_val   = 3'(d);
        @(posedge clk);
        #1;
        ce = cyc;
        dice_valid = 1'b0;
        if (d >= 1 && d <= 6) begin
            pos = (m_turn == 1) ? m_p1 : m_p2;
            s   = pos + d;
            if (s > 49) begin
                np = pos;
                ev = 3;
            end else begin
                np = bmap(s);
                ev = (np < s) ? 2 : (np > s) ? 1 : 0;
            end
            if (m_turn == 1) m_p1 = np;
            else             m_p2 = np;
            if (np == 49) begin
                m_over = 1;
                m_win  = (m_turn == 1) ? 1 : 2;
            end else begin
                m_turn = 1 - m_turn;
            end
            sb.push_back('{m_p1, m_p2, ev, m_turn, m_over, m_win, ce + 2});
            repeat (3) @(posedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int p1_bounce[8] = '{4, 6, 6, 6, 6, 6, 5, 6};
        int p1_win[8]    = '{4, 6, 6, 6, 6, 6, 5, 4};
        bit ok;

        reset = 1'b1; start_game = 1'b0; dice_valid = 1'b0; dice_val = 3'd0;
        model_reset();
        apply_reset("rst0");

        // First move: plain 0->3, turn passes to P2
        start_game = 1'b1;
        roll(3);
        check_model("plain");

        // Ladder, plain, then snake for P1
        apply_reset("rst1");
        start_game = 1'b1;
        roll(5);
        roll(6);
        roll(1);
        check_model("snake");

        // Illegal faces are swallowed without a move
        roll(0);
        roll(7);
        check_model("illegal");
        roll(2);

        // Pause while waiting for dice, then resume with the same player
        @(negedge clk);
        start_game = 1'b0; dice_valid = 1'b1; dice_val = 3'd3;
        repeat (3) @(negedge clk);
        chk("pause_ready", dice_ready, 0);
        check_model("pause");
        dice_valid = 1'b0;
        start_game = 1'b1;
        roll(4);
        check_model("resume");

        // Overshoot from 45 bounces and still passes the turn
        apply_reset("rst2");
        start_game = 1'b1;
        foreach (p1_bounce[i]) begin
            roll(p1_bounce[i]);
            roll(1);
        end
        chk("pre_bounce_p1", p1_position, 45);
        roll(6);
        check_model("bounce");

        // 43 + 6 reaches the last square; game freezes
        apply_reset("rst3");
        start_game = 1'b1;
        foreach (p1_win[i]) begin
            roll(p1_win[i]);
            roll(1);
        end
        chk("pre_win_p1", p1_position, 43);
        roll(6);
        dice_valid = 1'b1; dice_val = 3'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("done_ready", dice_ready, 0);
        end
        dice_valid = 1'b0;
        check_model("done");

        // Reset one cycle after a handshake aborts the move
        apply_reset("rst4");
        start_game = 1'b1;
        wait_ready(ok);
        dice_valid = 1'b1; dice_val = 3'd4;
        @(posedge clk);
        #1;
        dice_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1; start_game = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check_reset_vals("abort");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_mv", move_valid, 0);
        end

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
